seq_restoring_divider: RTL and testbench

- Multi-cycle integer divider for the ALU's DIV/DIVU path.
- Performs one trial subtraction per clock (restore on borrow) and produces quotient (LO) and remainder (HI).
- Sits beside the combinational adder/subtractor in the ALU, driven by the control unit via a start/done handshake.

---
 rtl/seq_restoring_divider.sv | 150 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider for DIV/DIVU (quotient LO, remainder HI)
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    // Counter holds WIDTH trial steps plus one final sign fix-up cycle.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    // Partial remainder never exceeds the divisor magnitude, so WIDTH bits
    // hold it; the trial subtraction itself is done at WIDTH+1 bits.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] divisor_mag_q, divisor_mag_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             dividend_neg;
    logic             divisor_neg;

    // Next-state, datapath step and result fix-up.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rem_d         = rem_q;
        dq_d          = dq_q;
        divisor_mag_d = divisor_mag_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        zero_d        = zero_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_zero_d    = div_zero_q;

        rem_sh       = {rem_q, dq_q[WIDTH-1]};
        trial        = rem_sh - {1'b0, divisor_mag_q};
        dividend_neg = signed_op & dividend[WIDTH-1];
        divisor_neg  = signed_op & divisor[WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RUN;
                    busy_d        = 1'b1;
                    neg_quo_d     = dividend_neg ^ divisor_neg;
                    neg_rem_d     = dividend_neg;
                    dq_d          = dividend_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
                    divisor_mag_d = divisor_neg ? ({WIDTH{1'b0}} - divisor) : divisor;
                    rem_d         = '0;
                    count_d       = CW'(WIDTH);
                    zero_d        = (divisor == '0);
                end
            end
            S_RUN: begin
                if (count_q != '0) begin
                    // Keep the subtraction only when it did not borrow.
                    rem_d   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    dq_d    = {dq_q[WIDTH-2:0], ~trial[WIDTH]};
                    count_d = count_q - 1'b1;
                end else begin
                    // Divide-by-zero leaves all-ones quotient bits and the dividend
                    // magnitude in rem; the sign restore returns the original dividend.
                    quotient_d  = zero_q ? {WIDTH{1'b1}}
                                : (neg_quo_q ? ({WIDTH{1'b0}} - dq_q) : dq_q);
                    remainder_d = neg_rem_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                    div_zero_d  = zero_q;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            rem_q         <= '0;
            dq_q          <= '0;
            divisor_mag_q <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            zero_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_zero_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rem_q         <= rem_d;
            dq_q          <= dq_d;
            divisor_mag_q <= divisor_mag_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            zero_q        <= zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_zero_q    <= div_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int errors = 0;
    int checks = 0;

    int           o_lat;
    int           o_dones;
    bit           o_busy_ok;
    logic [W-1:0] o_q;
    logic [W-1:0] o_r;
    logic         o_dz;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division at 64 bits, truncated to W bits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint x;
        longint y;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            if (s) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'b0, a});
                y = longint'({32'b0, b});
            end
            q  = W'(x / y);
            r  = W'(x % y);
            dz = 1'b0;
        end
    endtask

    // Issue one operation at edge k and observe edges k+1 .. k+W+3.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        o_lat     = -1;
        o_dones   = 0;
        o_busy_ok = 1'b1;
        o_q       = 'x;
        o_r       = 'x;
        o_dz      = 1'bx;
        for (int j = 1; j <= W + 3; j++) begin
            dividend  = $urandom;
            divisor   = $urandom;
            signed_op = 1'($urandom);
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                o_dones++;
                if (o_lat < 0) begin
                    o_lat = j;
                    o_q   = quotient;
                    o_r   = remainder;
                    o_dz  = div_zero;
                end
            end
            if (j <= W + 1 && busy !== 1'b1) o_busy_ok = 1'b0;
            if (j >= W + 2 && busy !== 1'b0) o_busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q: got %h expected 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r: got %h expected 0", remainder); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
    endtask

    task automatic test_unsigned_latency();
        run_op(32'd100, 32'd7, 1'b0);
        checks++; if (o_lat !== W + 1) begin errors++; $display("FAIL latency: got %0d expected %0d", o_lat, W + 1); end
        checks++; if (o_dones !== 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", o_dones); end
        checks++; if (o_busy_ok !== 1'b1) begin errors++; $display("FAIL busy_window: got %b expected 1", o_busy_ok); end
        checks++; if (o_q !== 32'd14) begin errors++; $display("FAIL divu_q: got %h expected %h", o_q, 32'd14); end
        checks++; if (o_r !== 32'd2) begin errors++; $display("FAIL divu_r: got %h expected %h", o_r, 32'd2); end
        checks++; if (o_dz !== 1'b0) begin errors++; $display("FAIL divu_dz: got %b expected 0", o_dz); end
    endtask

    task automatic test_signed();
        logic [W-1:0] ta [3] = '{32'hFFFF_FFF9, 32'd7,          32'hFFFF_FFF9};
        logic [W-1:0] tb [3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [W-1:0] eq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
        logic [W-1:0] er [3] = '{32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b1);
            checks++; if (o_lat !== W + 1) begin errors++; $display("FAIL signed_lat[%0d]: got %0d expected %0d", i, o_lat, W + 1); end
            checks++; if (o_q !== eq[i]) begin errors++; $display("FAIL signed_q[%0d]: got %h expected %h", i, o_q, eq[i]); end
            checks++; if (o_r !== er[i]) begin errors++; $display("FAIL signed_r[%0d]: got %h expected %h", i, o_r, er[i]); end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] ta [3] = '{32'h1234_5678, 32'hFFFF_FFFB, 32'd10};
        logic [W-1:0] tb [3] = '{32'd0,         32'd0,         32'd3};
        logic [W-1:0] eq [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [W-1:0] er [3] = '{32'h1234_5678, 32'hFFFF_FFFB, 32'd1};
        logic         ez [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b1);
            checks++; if (o_lat !== W + 1) begin errors++; $display("FAIL dz_lat[%0d]: got %0d expected %0d", i, o_lat, W + 1); end
            checks++; if (o_q !== eq[i]) begin errors++; $display("FAIL dz_q[%0d]: got %h expected %h", i, o_q, eq[i]); end
            checks++; if (o_r !== er[i]) begin errors++; $display("FAIL dz_r[%0d]: got %h expected %h", i, o_r, er[i]); end
            checks++; if (o_dz !== ez[i]) begin errors++; $display("FAIL dz_flag[%0d]: got %b expected %b", i, o_dz, ez[i]); end
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ta [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
        logic [W-1:0] tb [3] = '{32'hFFFF_FFFF, 32'd1,         32'd9};
        logic         ts [3] = '{1'b1, 1'b0, 1'b0};
        logic [W-1:0] eq [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        logic [W-1:0] er [3] = '{32'd0,         32'd0,         32'd5};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], ts[i]);
            checks++; if (o_q !== eq[i]) begin errors++; $display("FAIL bound_q[%0d]: got %h expected %h", i, o_q, eq[i]); end
            checks++; if (o_r !== er[i]) begin errors++; $display("FAIL bound_r[%0d]: got %h expected %h", i, o_r, er[i]); end
            checks++; if (o_dz !== 1'b0) begin errors++; $display("FAIL bound_dz[%0d]: got %b expected 0", i, o_dz); end
        end
    endtask

    task automatic test_mid_run_reset();
        int seen;
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL abort_q: got %h expected 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL abort_r: got %h expected 0", remainder); end
        seen = 0;
        for (int j = 0; j < W + 8; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int dones1;
        int lat2;
        int dones2;
        logic [W-1:0] q1;
        logic [W-1:0] r1;
        logic [W-1:0] q2;
        logic [W-1:0] r2;
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd10;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        lat1   = -1;
        dones1 = 0;
        q1     = 'x;
        r1     = 'x;
        for (int j = 1; j <= W + 2; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dones1++;
                if (lat1 < 0) begin lat1 = j; q1 = quotient; r1 = remainder; end
            end
            dividend  = 32'd7;
            divisor   = 32'd7;
            start     = (j + 1 == 5 || j + 1 == W + 1 || j + 1 == W + 3);
            if (j + 1 == W + 3) begin
                dividend = 32'd77;
                divisor  = 32'd5;
            end
        end
        checks++; if (lat1 !== W + 1) begin errors++; $display("FAIL b2b_lat1: got %0d expected %0d", lat1, W + 1); end
        checks++; if (dones1 !== 1) begin errors++; $display("FAIL b2b_pulses1: got %0d expected 1", dones1); end
        checks++; if (q1 !== 32'd100) begin errors++; $display("FAIL b2b_q1: got %h expected %h", q1, 32'd100); end
        checks++; if (r1 !== 32'd0) begin errors++; $display("FAIL b2b_r1: got %h expected 0", r1); end
        @(posedge clk);
        #1;
        start  = 1'b0;
        lat2   = -1;
        dones2 = 0;
        q2     = 'x;
        r2     = 'x;
        for (int j = 1; j <= W + 3; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dones2++;
                if (lat2 < 0) begin lat2 = j; q2 = quotient; r2 = remainder; end
            end
        end
        checks++; if (lat2 !== W + 1) begin errors++; $display("FAIL b2b_lat2: got %0d expected %0d", lat2, W + 1); end
        checks++; if (dones2 !== 1) begin errors++; $display("FAIL b2b_pulses2: got %0d expected 1", dones2); end
        checks++; if (q2 !== 32'd15) begin errors++; $display("FAIL b2b_q2: got %h expected %h", q2, 32'd15); end
        checks++; if (r2 !== 32'd2) begin errors++; $display("FAIL b2b_r2: got %h expected %h", r2, 32'd2); end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = {W{1'b1}} - W'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = W'($urandom_range(0, 200));
            s = 1'($urandom);
            model(a, b, s, eq, er, ez);
            run_op(a, b, s);
            checks++; if (o_lat !== W + 1) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", i, o_lat, W + 1); end
            checks++; if (o_q !== eq) begin errors++; $display("FAIL rnd_q[%0d] a=%h b=%h s=%b: got %h expected %h", i, a, b, s, o_q, eq); end
            checks++; if (o_r !== er) begin errors++; $display("FAIL rnd_r[%0d] a=%h b=%h s=%b: got %h expected %h", i, a, b, s, o_r, er); end
            checks++; if (o_dz !== ez) begin errors++; $display("FAIL rnd_dz[%0d]: got %b expected %b", i, o_dz, ez); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_div_zero();
        test_boundaries();
        test_mid_run_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
